// File: rtl/clock_increment.sv
// rtl/clock_increment.sv - programmable up-counting timer with prescaler, pause/resume and done pulse
//
// Counts from 0 up to a target latched when a run begins, advancing once every
// PRESCALE clock cycles, then parks in DONE holding the target value.
//
// Ports:
//   clk          rising-edge system clock
//   rst          asynchronous active-high reset
//   start        begins a run from IDLE/DONE, resumes from PAUSED
//   pause        freezes a run in RUN (takes precedence over start)
//   clear        synchronous return to IDLE from any state (highest precedence)
//   target       terminal count, sampled only on the cycle a run begins
//   count_output current count
//   running      high while in RUN
//   paused       high while in PAUSED
//   done         high while in DONE
//   done_pulse   one-cycle pulse on entry to DONE

module clock_increment #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] count_output,
  output logic             running,
  output logic             paused,
  output logic             done,
  output logic             done_pulse
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    pre_cnt;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] count_next;

  // Incremented count kept at WIDTH bits; the run stops on reaching target_q,
  // so this never needs to represent a wrapped value.
  assign count_next = count_output + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count_output <= '0;
      pre_cnt      <= '0;
      target_q     <= '0;
      done_pulse   <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (clear) begin
        state        <= IDLE;
        count_output <= '0;
        pre_cnt      <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              target_q     <= target;
              count_output <= '0;
              pre_cnt      <= '0;
              if (target == '0) begin
                state      <= DONE;
                // A held start with a zero target re-enters DONE every cycle;
                // alternate so the pulse is never high two cycles in a row.
                done_pulse <= ~done_pulse;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            // A tick on the same edge as pause is dropped: count and pre_cnt hold.
            if (pause) begin
              state <= PAUSED;
            end else if (pre_cnt == PRE_LAST) begin
              pre_cnt      <= '0;
              count_output <= count_next;
              if (count_next == target_q) begin
                state      <= DONE;
                done_pulse <= 1'b1;
              end
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
          PAUSED: begin
            if (start && !pause) begin
              state <= RUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign running = (state == RUN);
  assign paused  = (state == PAUSED);
  assign done    = (state == DONE);

endmodule
